// File: rtl/sram_read_serializer_pkg.sv
// Shared definitions for the SRAM read-back serializer: FSM encoding and default sizing.
// Frame length grows by one parity bit when SRAM_RD_PARITY_EN is defined.
package sram_read_serializer_pkg;

  localparam int DEF_DATA_W        = 8;
  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int MAX_ACCESS_CYCLES = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCESS  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  function automatic int frame_bits(input int data_w);
`ifdef SRAM_RD_PARITY_EN
    return data_w + 1;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/sram_read_serializer_if.sv
// Request/SRAM/serial-out bundle between the AVR-side controller and the read serializer.
// master drives the request and SRAM data; slave is the serializer itself.
interface sram_read_serializer_if #(
  parameter int DATA_W = sram_read_serializer_pkg::DEF_DATA_W
);
  logic              rd_req;
  logic [DATA_W-1:0] sram_data_in;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              avr_so;
  logic              so_valid;
  logic              busy;
  logic              done;

  modport master (
    output rd_req, sram_data_in,
    input  sram_ce_n, sram_oe_n, avr_so, so_valid, busy, done
  );

  modport slave (
    input  rd_req, sram_data_in,
    output sram_ce_n, sram_oe_n, avr_so, so_valid, busy, done
  );
endinterface

// File: rtl/sram_read_serializer_piso_shifter.sv
// MSB-first parallel-in/serial-out register; the output stage idles high and is separate from the
// lower DATA_W-1 bits so it can reset to 1 while the data bits clear. Requires DATA_W >= 3.
module piso_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_idle,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_dat,
  output logic              o_so
);

  logic [DATA_W-2:0] r_sh;
  logic              r_so;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
      r_so <= 1'b1;
    end else if (i_load) begin
      r_so <= i_dat[DATA_W-1];
      r_sh <= i_dat[DATA_W-2:0];
    end else if (i_idle) begin
      r_so <= 1'b1;
    end else if (i_shift) begin
      r_so <= r_sh[DATA_W-2];
      r_sh <= {r_sh[DATA_W-3:0], i_fill};
    end
  end

  assign o_so = r_so;

endmodule

// File: rtl/sram_read_serializer.sv
// Runs one SRAM read at the held address, then shifts the byte MSB-first to the AVR on avr_so.
// Optional trailing even-parity bit when SRAM_RD_PARITY_EN is defined.
module sram_read_serializer
  import sram_read_serializer_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input  logic                  avr_clk,
  input  logic                  avr_rst_n,
  sram_read_serializer_if.slave bus
);

  localparam int FRAME_BITS = frame_bits(DATA_W);
  localparam int ACC_W      = $clog2(MAX_ACCESS_CYCLES + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);

  localparam logic [ACC_W-1:0] ACC_LOAD = ACC_W'(ACCESS_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_vld;
  logic             r_busy;
  logic             r_done;

  logic w_load;
  logic w_last;
  logic w_shift;
  logic w_fill;
  logic w_so;

  assign w_load  = (r_state == ST_CAPTURE);
  assign w_last  = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
  assign w_shift = (r_state == ST_SHIFT) && !w_last;

`ifdef SRAM_RD_PARITY_EN
  logic r_par;

  // Parity enters at the first shift and reaches the output stage right after the LSB.
  assign w_fill = r_par;

  always_ff @(posedge avr_clk or negedge avr_rst_n) begin
    if (!avr_rst_n) begin
      r_par <= 1'b0;
    end else if (w_load) begin
      r_par <= ^bus.sram_data_in;
    end
  end
`else
  assign w_fill = 1'b0;
`endif

  piso_shifter #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk     (avr_clk),
    .rst_n   (avr_rst_n),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_idle  (w_last),
    .i_fill  (w_fill),
    .i_dat   (bus.sram_data_in),
    .o_so    (w_so)
  );

  always_ff @(posedge avr_clk or negedge avr_rst_n) begin
    if (!avr_rst_n) begin
      r_state   <= ST_IDLE;
      r_acc_cnt <= '0;
      r_bit_cnt <= '0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_vld     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.rd_req) begin
            r_state   <= ST_ACCESS;
            r_acc_cnt <= ACC_LOAD;
            r_ce_n    <= 1'b0;
            r_oe_n    <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (r_acc_cnt == '0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_acc_cnt <= r_acc_cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          r_state   <= ST_SHIFT;
          r_ce_n    <= 1'b1;
          r_oe_n    <= 1'b1;
          r_vld     <= 1'b1;
          r_bit_cnt <= '0;
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_vld   <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.sram_ce_n = r_ce_n;
  assign bus.sram_oe_n = r_oe_n;
  assign bus.avr_so    = w_so;
  assign bus.so_valid  = r_vld;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_sram_read_serializer.sv
// Scoreboard bench for sram_read_serializer: expected frame bits and done pulses are queued at
// stimulus time and consumed by an independent negedge monitor.
module tb_sram_read_serializer;

`ifdef SRAM_RD_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif
  localparam int AC = 2;

  logic clk;
  logic rst_n;

  sram_read_serializer_if #(.DATA_W(8)) bus();

  sram_read_serializer #(
    .DATA_W        (8),
    .ACCESS_CYCLES (AC)
  ) dut (
    .avr_clk   (clk),
    .avr_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec;
  int   n_err;
  int   exp_done;
  logic q_bits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frames are written as 9 bits {data, parity}; without parity only the top 8 are sent.
  task automatic push_frame(input logic [8:0] f);
    for (int i = 0; i < FB; i++) q_bits.push_back(f[8-i]);
    exp_done++;
  endtask

  task automatic pulse_req(input logic [7:0] d);
    @(negedge clk);
    bus.sram_data_in = d;
    bus.rd_req       = 1'b1;
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int at;
    at = 0;
    for (int n = 1; n <= max; n++) begin
      @(negedge clk);
      if (bus.done) begin
        at = n;
        break;
      end
    end
    chk(nm, 32'(at != 0), 32'd1);
  endtask

  // Monitor: every valid bit and every done pulse must have been announced by the stimulus.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.so_valid) begin
          if (q_bits.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_bit: avr_so=%0b with no bit expected (t=%0t)", bus.avr_so, $time);
          end else begin
            chk("avr_so", 32'(bus.avr_so), 32'(q_bits.pop_front()));
          end
        end
        if (bus.done) begin
          if (exp_done == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: done pulse with none expected (t=%0t)", $time);
          end else begin
            n_vec++;
            exp_done--;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, ce_low, oe_low, dn, v, d;
    bit poked;
    n_vec = 0; n_err = 0; exp_done = 0;
    rst_n = 1'b0;
    bus.rd_req = 1'b0;
    bus.sram_data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.so_valid, bus.busy, bus.done}), 32'b111000);
    rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.so_valid, bus.busy, bus.done}), 32'b111000);
    end

    // Single read of A5: timing of strobes, first bit and done
    push_frame(9'b1010_0101_0);
    pulse_req(8'hA5);
    first = 0; ce_low = 0; oe_low = 0; dn = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.so_valid && first == 0) first = n;
      if (!bus.sram_ce_n) ce_low++;
      if (!bus.sram_oe_n) oe_low++;
      if (bus.done) begin
        dn = n;
        break;
      end
    end
    chk("first_valid_cycle", 32'(first), 32'(AC + 2));
    chk("ce_low_cycles", 32'(ce_low), 32'(AC + 1));
    chk("oe_low_cycles", 32'(oe_low), 32'(AC + 1));
    chk("done_cycle", 32'(dn), 32'(AC + FB + 2));
    @(negedge clk);
    chk("after_done_idle", 32'({bus.busy, bus.done, bus.avr_so, bus.so_valid}), 32'b0010);

    // rd_req held high: 3C then FF, one idle cycle between frames
    push_frame(9'b0011_1100_0);
    push_frame(9'b1111_1111_0);
    @(negedge clk);
    bus.sram_data_in = 8'h3C;
    bus.rd_req = 1'b1;
    wait_done("b2b_first_done", 40);
    bus.sram_data_in = 8'hFF;
    @(negedge clk);
    chk("b2b_gap_idle", 32'({bus.busy, bus.sram_ce_n}), 32'b01);
    @(negedge clk);
    chk("b2b_restart", 32'({bus.busy, bus.sram_ce_n}), 32'b10);
    bus.rd_req = 1'b0;
    wait_done("b2b_second_done", 40);

    // rd_req pulsed during SHIFT is ignored
    push_frame(9'b0101_1010_0);
    pulse_req(8'h5A);
    v = 0; d = 0; poked = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.so_valid) v++;
      if (bus.done) d++;
      if (poked && bus.rd_req) bus.rd_req = 1'b0;
      if (v == 3 && !poked) begin
        bus.rd_req = 1'b1;
        poked = 1'b1;
      end
    end
    chk("busy_req_frame_bits", 32'(v), 32'(FB));
    chk("busy_req_done_count", 32'(d), 32'd1);

    // Reset at the third SHIFT bit: immediate abort, no done
    q_bits.push_back(1'b1);
    q_bits.push_back(1'b1);
    q_bits.push_back(1'b0);
    pulse_req(8'hC3);
    v = 0;
    for (int n = 0; n < 20 && v < 3; n++) begin
      @(negedge clk);
      if (bus.so_valid) v++;
    end
    chk("reached_third_bit", 32'(v), 32'd3);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.avr_so, bus.so_valid, bus.busy, bus.done}), 32'b111000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(bus.done), 32'd0);
    push_frame(9'b1000_0000_1);
    pulse_req(8'h80);
    wait_done("post_reset_done", 40);

    // Parity patterns
    push_frame(9'b0000_0111_1);
    pulse_req(8'h07);
    wait_done("par07_done", 40);
    push_frame(9'b0000_0011_0);
    pulse_req(8'h03);
    wait_done("par03_done", 40);

    repeat (5) @(negedge clk);
    chk("bits_left", 32'(q_bits.size()), 32'd0);
    chk("dones_left", 32'(exp_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
